// File: rtl/weight_pkg.sv
// Shared types and constants for the weight tile buffer.
package weight_pkg;

  localparam int TILE_DIM   = 6;
  localparam int TILE_ELEMS = TILE_DIM * TILE_DIM;
  localparam int DATA_W     = 12;

  // One 6x6 tile of signed elements, addressed as tile[row][col].
  typedef logic signed [TILE_DIM-1:0][TILE_DIM-1:0][DATA_W-1:0] tile_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } wb_state_e;

endpackage

// File: rtl/weight_tile_loader.sv
// Deserializes the row-major element stream into 6x6 tiles. The element
// that completes a tile is merged combinationally into tile_o so the
// parent can write the full tile in the same cycle tile_done_o is high.
module weight_tile_loader
  import weight_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              accept_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              tile_done_o,
  output tile_t             tile_o
);

  logic [5:0] e_q, e_d;
  logic [2:0] row_q, row_d;
  logic [2:0] col_q, col_d;
  tile_t      buf_q;
  logic       last_elem;

  assign last_elem   = (e_q == 6'(TILE_ELEMS - 1));
  assign tile_done_o = accept_i & last_elem;

  // Next element position: col runs 0..5, row advances on column wrap.
  always_comb begin
    e_d   = e_q;
    row_d = row_q;
    col_d = col_q;
    if (accept_i) begin
      if (last_elem) begin
        e_d   = '0;
        row_d = '0;
        col_d = '0;
      end else begin
        e_d = e_q + 6'd1;
        if (col_q == 3'(TILE_DIM - 1)) begin
          col_d = '0;
          row_d = row_q + 3'd1;
        end else begin
          col_d = col_q + 3'd1;
        end
      end
    end
  end

  // Position counters; reset discards any partially assembled tile.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e_q   <= '0;
      row_q <= '0;
      col_q <= '0;
    end else begin
      e_q   <= e_d;
      row_q <= row_d;
      col_q <= col_d;
    end
  end

  // Element placement; contents are meaningless until a tile completes.
  always_ff @(posedge clk) begin
    if (accept_i) buf_q[row_q][col_q] <= data_i;
  end

  // Full tile view with the final element taken straight from the stream.
  always_comb begin
    tile_o = buf_q;
    tile_o[TILE_DIM-1][TILE_DIM-1] = data_i;
  end

endmodule

// File: rtl/weight_buffer_responder.sv
// Weight tile store: loaded from an element stream, read two adjacent
// tiles per request with one cycle latency. Optional address range
// checking is enabled with the WEIGHT_BUF_ADDR_CHECK_EN macro.
//
// Load handshake: an element transfers on a rising edge where both
// load_valid_i and load_ready_o are high; either side may hold off
// freely and data must be stable while valid is high and ready is low.
module weight_buffer_responder
  import weight_pkg::*;
#(
  parameter int DEPTH  = 64,
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              weight_req_i,
  input  logic [ADDR_W-1:0] weight_addr_i,
  output tile_t             weight_data_o_1,
  output tile_t             weight_data_o_2,
  output logic              weight_valid_o,
  output logic              busy_o,
  input  logic              load_start_i,
  input  logic [ADDR_W-1:0] load_base_i,
  input  logic [7:0]        load_tiles_i,
  input  logic              load_valid_i,
  input  logic [DATA_W-1:0] load_data_i,
  output logic              load_ready_o,
  output logic              load_done_o,
`ifdef WEIGHT_BUF_ADDR_CHECK_EN
  output logic              addr_err_o,
`endif
  output wb_state_e         state_o
);

  localparam int IDX_W = $clog2(DEPTH);

  wb_state_e        state_q;
  logic [IDX_W-1:0] base_q;
  logic [7:0]       tiles_q;
  logic [7:0]       t_q;
  logic             busy_q, ready_q, done_q;
  logic             valid_q;
  tile_t            data1_q, data2_q;
  tile_t            store_q [DEPTH];

  logic             accept;
  logic             tile_done;
  tile_t            tile_fill;
  logic             rd_fire;
  logic [IDX_W-1:0] rd_idx_1, rd_idx_2, wr_idx;
  logic             unused_hi;

  assign accept   = ready_q & load_valid_i;
  assign rd_fire  = weight_req_i & (state_q == IDLE);
  assign rd_idx_1 = weight_addr_i[IDX_W-1:0];
  assign rd_idx_2 = rd_idx_1 + IDX_W'(1);
  assign wr_idx   = base_q + IDX_W'(t_q);

  // Address bits above the store index are not used for addressing.
  assign unused_hi = ^{weight_addr_i[ADDR_W-1:IDX_W], load_base_i[ADDR_W-1:IDX_W]};

  weight_tile_loader u_loader (
    .clk         (clk),
    .rst_n       (reset),
    .accept_i    (accept),
    .data_i      (load_data_i),
    .tile_done_o (tile_done),
    .tile_o      (tile_fill)
  );

  // Load control FSM with registered status outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      base_q  <= '0;
      tiles_q <= '0;
      t_q     <= '0;
      busy_q  <= 1'b0;
      ready_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (load_start_i) begin
            if (load_tiles_i != 8'd0) begin
              state_q <= LOAD;
              base_q  <= load_base_i[IDX_W-1:0];
              tiles_q <= load_tiles_i;
              t_q     <= '0;
              busy_q  <= 1'b1;
              ready_q <= 1'b1;
            end else begin
              done_q <= 1'b1;
            end
          end
        end
        LOAD: begin
          if (tile_done) begin
            t_q <= t_q + 8'd1;
            if (t_q == tiles_q - 8'd1) begin
              state_q <= DONE;
              busy_q  <= 1'b0;
              ready_q <= 1'b0;
              done_q  <= 1'b1;
            end
          end
        end
        DONE: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // Tile store write; the index wraps naturally at DEPTH.
  always_ff @(posedge clk) begin
    if (tile_done) store_q[wr_idx] <= tile_fill;
  end

  // Read pipeline: one stage, data held between requests.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q <= 1'b0;
      data1_q <= '0;
      data2_q <= '0;
    end else begin
      valid_q <= rd_fire;
      if (rd_fire) begin
        data1_q <= store_q[rd_idx_1];
        data2_q <= store_q[rd_idx_2];
      end
    end
  end

`ifdef WEIGHT_BUF_ADDR_CHECK_EN
  logic err_q;
  logic req_oob, load_oob;

  assign req_oob  = rd_fire &&
                    (({1'b0, weight_addr_i} + (ADDR_W+1)'(1)) >= (ADDR_W+1)'(DEPTH));
  assign load_oob = (state_q == IDLE) && load_start_i && (load_tiles_i != 8'd0) &&
                    (({1'b0, load_base_i} + (ADDR_W+1)'(load_tiles_i)) > (ADDR_W+1)'(DEPTH));

  // Sticky range error flag, cleared only by reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) err_q <= 1'b0;
    else        err_q <= err_q | req_oob | load_oob;
  end

  assign addr_err_o = err_q;
`endif

  assign weight_data_o_1 = data1_q;
  assign weight_data_o_2 = data2_q;
  assign weight_valid_o  = valid_q;
  assign busy_o          = busy_q;
  assign load_ready_o    = ready_q;
  assign load_done_o     = done_q;
  assign state_o         = state_q;

endmodule
